// File: rtl/nand_stim_gen_if.sv
// Control and pattern bundle between the NAND stimulus generator and whatever drives/consumes it.
// The master side is the generator; the slave side issues start/pause/abort and reads the pattern.
interface nand_stim_gen_if;
  logic       start;
  logic       pause;
  logic       abort;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic [3:0] step;
  logic       sample;
  logic       valid;
  logic       busy;
  logic       done;

  modport master (
    input  start, pause, abort,
    output a, b, c, d, step, sample, valid, busy, done
  );

  modport slave (
    output start, pause, abort,
    input  a, b, c, d, step, sample, valid, busy, done
  );
endinterface

// File: rtl/nand_stim_gen.sv
// Binary-count stimulus for the 4-input NAND block: holds each pattern TICKS_PER_STEP clocks,
// strobes sample in the last cycle of each step, and supports start/pause/abort.
module nand_stim_gen #(
  parameter int TICKS_PER_STEP = 50,
  parameter int NUM_STEPS      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  nand_stim_gen_if.master    bus
);

  localparam int TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_STEP - 1);
  localparam logic [3:0]    LAST_STEP = 4'(NUM_STEPS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   tick_reg, tick_next;
  logic [3:0]      step_reg, step_next;
  logic            sample_reg, sample_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      tick_reg   <= '0;
      step_reg   <= '0;
      sample_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tick_reg   <= tick_next;
      step_reg   <= step_next;
      sample_reg <= sample_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    step_next  = step_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_next = ST_RUN;
          tick_next  = '0;
          step_next  = '0;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (bus.pause) begin
          state_next = ST_PAUSE;
        end else begin
          // The release cycle counts as a run cycle, so paused time is exactly the pause-high time.
          state_next = ST_RUN;
          if (tick_reg == LAST_TICK) begin
            tick_next = '0;
            if (step_reg == LAST_STEP) begin
              state_next = ST_DONE;
            end else begin
              step_next = step_reg + 4'd1;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (bus.abort) begin
      state_next = ST_IDLE;
      tick_next  = '0;
      step_next  = '0;
    end

    // Registered strobe lines up with the cycle in which tick_cnt sits at its last value.
    sample_next = (state_next == ST_RUN) && (tick_next == LAST_TICK);
  end

  assign bus.a      = step_reg[0];
  assign bus.b      = step_reg[1];
  assign bus.c      = step_reg[2];
  assign bus.d      = step_reg[3];
  assign bus.step   = step_reg;
  assign bus.sample = sample_reg;
  assign bus.busy   = (state_reg == ST_RUN) || (state_reg == ST_PAUSE);
  assign bus.valid  = (state_reg == ST_RUN) || (state_reg == ST_PAUSE);
  assign bus.done   = (state_reg == ST_DONE);

endmodule

// File: tb/tb_nand_stim_gen.sv
// Directed bench for nand_stim_gen: a 4-tick/16-step instance and a 1-tick/4-step instance.
module tb_nand_stim_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   checks  = 0;
  int   errors  = 0;
  int   samples = 0;

  always #5 clk = ~clk;

  nand_stim_gen_if bus4();
  nand_stim_gen_if bus1();

  nand_stim_gen #(.TICKS_PER_STEP(4), .NUM_STEPS(16)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  nand_stim_gen #(.TICKS_PER_STEP(1), .NUM_STEPS(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Packed view: {step, d,c,b,a, sample, valid, busy, done}
  function automatic logic [31:0] word4();
    return {20'd0, bus4.step, bus4.d, bus4.c, bus4.b, bus4.a,
            bus4.sample, bus4.valid, bus4.busy, bus4.done};
  endfunction

  function automatic logic [31:0] word1();
    return {20'd0, bus1.step, bus1.d, bus1.c, bus1.b, bus1.a,
            bus1.sample, bus1.valid, bus1.busy, bus1.done};
  endfunction

  function automatic logic [31:0] exp_word(input logic [3:0] st, input logic [3:0] pat,
                                           input logic s, input logic v,
                                           input logic bz, input logic dn);
    return {20'd0, st, pat, s, v, bz, dn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start4();
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  // Checks ncyc run cycles of dut4 starting at cycle 0; optionally pauses plen cycles at pause_at.
  task automatic run4(input int ncyc, input int pause_at, input int plen);
    for (int i = 0; i < ncyc; i++) begin
      logic [3:0] st;
      st = 4'(i / 4);
      chk($sformatf("run_c%0d", i), word4(), exp_word(st, st, (i % 4) == 3, 1'b1, 1'b1, 1'b0));
      if (bus4.sample) samples++;
      if (i == pause_at) begin
        bus4.pause = 1'b1;
        for (int p = 0; p < plen; p++) begin
          @(negedge clk);
          chk($sformatf("pause_p%0d", p), word4(), exp_word(st, st, 1'b0, 1'b1, 1'b1, 1'b0));
        end
        bus4.pause = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.pause = 1'b0; bus4.abort = 1'b0;
    bus1.start = 1'b0; bus1.pause = 1'b0; bus1.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset4", word4(), 32'd0);
    chk("reset1", word1(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", word4(), 32'd0);
    $display("reset: checks=%0d", checks);

    // Uninterrupted run
    samples = 0;
    start4();
    run4(64, -1, 0);
    chk("run1_done", word4(), exp_word(4'd15, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1));
    chk("run1_samples", 32'(samples), 32'd16);
    bus4.pause = 1'b1;
    repeat (2) @(negedge clk);
    chk("pause_in_done", word4(), exp_word(4'd15, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1));
    bus4.pause = 1'b0;
    $display("run from idle: samples=%0d", samples);

    // Restart from DONE
    samples = 0;
    start4();
    run4(64, -1, 0);
    chk("run2_done", word4(), exp_word(4'd15, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1));
    chk("run2_samples", 32'(samples), 32'd16);
    $display("restart from done: samples=%0d", samples);

    // Pause in step 5, tick 2, for 10 cycles
    samples = 0;
    start4();
    run4(64, 22, 10);
    chk("run3_done", word4(), exp_word(4'd15, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1));
    chk("run3_samples", 32'(samples), 32'd16);
    $display("paused run: samples=%0d", samples);

    // Abort at step 9 with start also high
    start4();
    run4(36, -1, 0);
    bus4.abort = 1'b1;
    bus4.start = 1'b1;
    @(negedge clk);
    chk("abort_idle", word4(), 32'd0);
    bus4.abort = 1'b0;
    bus4.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_restart", word4(), 32'd0);
    $display("abort at step 9: word=%h", word4());

    // Asynchronous reset at step 7
    start4();
    run4(28, -1, 0);
    chk("pre_reset_step7", word4(), exp_word(4'd7, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0));
    #2 rst_n = 1'b0;
    #1 chk("async_reset", word4(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", word4(), 32'd0);
    $display("async reset at step 7: word=%h", word4());

    // One tick per step, start held high through the run
    chk("dut1_idle", word1(), 32'd0);
    bus1.start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_c%0d", i), word1(), exp_word(4'(i), 4'(i), 1'b1, 1'b1, 1'b1, 1'b0));
      @(negedge clk);
    end
    chk("t1_done", word1(), exp_word(4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1));
    bus1.start = 1'b0;
    @(negedge clk);
    chk("t1_done_hold", word1(), exp_word(4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1));
    $display("ticks=1 run: word=%h", word1());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
